// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-back / write-allocate data cache
//               controller. 8 lines x 4 bytes, 3-bit tags, byte-wide CPU and
//               memory interfaces. Read hits return data in the request cycle.
//               Misses write back a dirty victim, fetch the new line into a
//               buffer and install it before the request is replayed as a hit.
// Options     : define DCACHE_STATS_EN to build the saturating hit/miss
//               statistics counters; otherwise HIT_COUNT/MISS_COUNT read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller #(
    parameter int STAT_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [7:0]            ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [7:0]            MEM_ADDRESS,
    output logic [7:0]            MEM_WRITEDATA,
    input  logic [7:0]            MEM_READDATA,
    input  logic                  MEM_BUSYWAIT,
    output logic [STAT_WIDTH-1:0] HIT_COUNT,
    output logic [STAT_WIDTH-1:0] MISS_COUNT
);

    // Controller states
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_FETCH     = 2'd2;
    localparam logic [1:0] c_UPDATE    = 2'd3;

    // Line storage: data and tag need no reset, valid/dirty do
    logic [31:0] r_data_q  [0:7];
    logic [2:0]  r_tag_q   [0:7];
    logic [7:0]  r_valid_q;
    logic [7:0]  r_dirty_q;

    // Miss sequencing
    logic [1:0]  r_state_q, r_state_d;
    logic [1:0]  r_cnt_q,   r_cnt_d;
    logic        r_seen_q,  r_seen_d;   // memory busy observed for current byte
    logic [31:0] r_buf_q;               // refill line buffer

    // Address decode and lookup
    logic [2:0]  w_index;
    logic [2:0]  w_tag;
    logic [1:0]  w_off;
    logic [31:0] w_line;
    logic [7:0]  w_byte;
    logic [7:0]  w_victim_byte;
    logic        w_req;
    logic        w_hit;
    logic        w_idle;
    logic        w_hit_evt;
    logic        w_wr_hit;
    logic        w_miss;
    logic        w_xfer_done;

    assign w_index       = ADDRESS[4:2];
    assign w_tag         = ADDRESS[7:5];
    assign w_off         = ADDRESS[1:0];
    assign w_line        = r_data_q[w_index];
    assign w_byte        = w_line[{w_off, 3'b000} +: 8];
    assign w_victim_byte = w_line[{r_cnt_q, 3'b000} +: 8];
    assign w_req         = READ | WRITE;
    assign w_hit         = r_valid_q[w_index] && (r_tag_q[w_index] == w_tag);
    assign w_idle        = (r_state_q == c_IDLE);

    // A request serviced in IDLE; simultaneous READ and WRITE acts as READ only
    assign w_hit_evt   = !RESET && w_idle && w_req && w_hit;
    assign w_wr_hit    = w_hit_evt && WRITE && !READ;
    assign w_miss      = !RESET && w_idle && w_req && !w_hit;

    // A byte completes once busy has been seen high and then drops
    assign w_xfer_done = r_seen_q && !MEM_BUSYWAIT;

    // Next-state, byte counter and busy-seen tracking
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_seen_d  = r_seen_q;
        case (r_state_q)
            c_IDLE: begin
                if (w_miss) begin
                    r_state_d = (r_valid_q[w_index] && r_dirty_q[w_index]) ? c_WRITEBACK : c_FETCH;
                    r_cnt_d   = 2'd0;
                    r_seen_d  = 1'b0;
                end
            end
            c_WRITEBACK, c_FETCH: begin
                if (MEM_BUSYWAIT) begin
                    r_seen_d = 1'b1;
                end else if (r_seen_q) begin
                    r_seen_d = 1'b0;
                    r_cnt_d  = r_cnt_q + 2'd1;   // wraps 3 -> 0 for the next state
                    if (r_cnt_q == 2'd3) begin
                        r_state_d = (r_state_q == c_WRITEBACK) ? c_FETCH : c_UPDATE;
                    end
                end
            end
            c_UPDATE: begin
                r_state_d = c_IDLE;
                r_cnt_d   = 2'd0;
                r_seen_d  = 1'b0;
            end
            default: begin
                r_state_d = c_IDLE;
                r_cnt_d   = 2'd0;
                r_seen_d  = 1'b0;
            end
        endcase
    end

    // Control state and line status bits; reset aborts any miss in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q <= c_IDLE;
            r_cnt_q   <= 2'd0;
            r_seen_q  <= 1'b0;
            r_valid_q <= 8'h00;
            r_dirty_q <= 8'h00;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_seen_q  <= r_seen_d;
            if (w_wr_hit) begin
                r_dirty_q[w_index] <= 1'b1;
            end
            if (r_state_q == c_UPDATE) begin
                r_valid_q[w_index] <= 1'b1;
                r_dirty_q[w_index] <= 1'b0;
            end
        end
    end

    // Data array, tag array and refill buffer; writes suppressed under reset
    always_ff @(posedge CLK) begin
        if (w_wr_hit) begin
            r_data_q[w_index][{w_off, 3'b000} +: 8] <= WRITEDATA;
        end
        if (!RESET && (r_state_q == c_FETCH) && w_xfer_done) begin
            r_buf_q[{r_cnt_q, 3'b000} +: 8] <= MEM_READDATA;
        end
        if (!RESET && (r_state_q == c_UPDATE)) begin
            r_data_q[w_index] <= r_buf_q;
            r_tag_q[w_index]  <= w_tag;
        end
    end

    // CPU and memory side outputs; everything held at zero while in reset
    always_comb begin
        READDATA      = 8'h00;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 8'h00;
        MEM_WRITEDATA = 8'h00;
        if (!RESET) begin
            case (r_state_q)
                c_IDLE: begin
                    BUSYWAIT = w_req && !w_hit;
                    if (READ && w_hit) begin
                        READDATA = w_byte;
                    end
                end
                c_WRITEBACK: begin
                    BUSYWAIT      = 1'b1;
                    MEM_WRITE     = 1'b1;
                    MEM_ADDRESS   = {r_tag_q[w_index], w_index, r_cnt_q};
                    MEM_WRITEDATA = w_victim_byte;
                end
                c_FETCH: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = {ADDRESS[7:2], r_cnt_q};
                end
                c_UPDATE: begin
                    BUSYWAIT = 1'b1;
                end
                default: begin
                    BUSYWAIT = 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [STAT_WIDTH-1:0] r_hit_cnt_q;
    logic [STAT_WIDTH-1:0] r_miss_cnt_q;

    // Saturating counters: one hit per serviced request, one miss per miss entry
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hit_cnt_q  <= '0;
            r_miss_cnt_q <= '0;
        end else begin
            if (w_hit_evt && (r_hit_cnt_q != {STAT_WIDTH{1'b1}})) begin
                r_hit_cnt_q <= r_hit_cnt_q + 1'b1;
            end
            if (w_miss && (r_miss_cnt_q != {STAT_WIDTH{1'b1}})) begin
                r_miss_cnt_q <= r_miss_cnt_q + 1'b1;
            end
        end
    end

    assign HIT_COUNT  = r_hit_cnt_q;
    assign MISS_COUNT = r_miss_cnt_q;
`else
    assign HIT_COUNT  = '0;
    assign MISS_COUNT = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Self-checking bench for dcache_controller. A flat byte array
//               gives the architectural value of every address; a per-index
//               valid/dirty/tag table predicts hits, misses and the exact
//               memory traffic each miss must produce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = 8'h00;
    logic [7:0]  WRITEDATA = 8'h00;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [7:0]  MEM_ADDRESS;
    logic [7:0]  MEM_WRITEDATA;
    logic [7:0]  mrd = 8'h00;
    logic        mbusy = 1'b0;
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;

    dcache_controller #(.STAT_WIDTH(16)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (mrd),
        .MEM_BUSYWAIT (mbusy),
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
    );

    always #5 CLK = ~CLK;

    // ---------------- memory responder ----------------
    logic [7:0]  mem [0:255];
    bit          mem_ready = 1'b0;
    logic [1:0]  mphase = 2'd0;
    int          mcnt = 0;
    int          lat = 2;
    logic [7:0]  maddr = 8'h00;
    logic        mwe = 1'b0;
    logic [7:0]  mwd = 8'h00;
    int          resp_err = 0;
    logic [16:0] obs [$];      // {is_write, address, write data}

    always @(posedge CLK) begin
        if (RESET) begin
            mbusy  <= 1'b0;
            mphase <= 2'd0;
            if (!mem_ready) begin
                for (int i = 0; i < 256; i++) mem[i] <= (i == 4) ? 8'h07 : 8'($urandom);
                mem_ready <= 1'b1;
            end
        end else begin
            if ((MEM_READ && MEM_WRITE) ||
                (mphase == 2'd1 && (MEM_ADDRESS !== maddr || MEM_WRITE !== mwe ||
                                    MEM_READ === mwe || (mwe && MEM_WRITEDATA !== mwd))))
                resp_err <= resp_err + 1;
            case (mphase)
                2'd0: if (MEM_READ || MEM_WRITE) begin
                    mbusy  <= 1'b1;
                    mcnt   <= lat;
                    maddr  <= MEM_ADDRESS;
                    mwe    <= MEM_WRITE;
                    mwd    <= MEM_WRITEDATA;
                    obs.push_back({MEM_WRITE, MEM_ADDRESS, MEM_WRITE ? MEM_WRITEDATA : 8'h00});
                    mphase <= 2'd1;
                end
                2'd1: begin
                    if (mcnt <= 1) begin
                        mbusy <= 1'b0;
                        if (mwe) mem[maddr] <= mwd;
                        else     mrd <= mem[maddr];
                        mphase <= 2'd2;
                    end else begin
                        mcnt <= mcnt - 1;
                    end
                end
                default: mphase <= 2'd0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] arch [0:255];
    bit         mv [0:7];
    bit         md [0:7];
    logic [2:0] mt [0:7];
    int         exp_hit = 0;
    int         exp_miss = 0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         err_seen = 0;
    int         last_base = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [15:0] stat_exp(input int v);
`ifdef DCACHE_STATS_EN
        return (v > 65535) ? 16'hFFFF : v[15:0];
`else
        return (v < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) arch[i] = mem[i];  // dirty data is lost on reset
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h04; WRITEDATA = 8'h55;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_busywait", BUSYWAIT, 0);
        chk("rst_mem_rw", {MEM_READ, MEM_WRITE}, 0);
        chk("rst_mem_addr", MEM_ADDRESS, 0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 0);
        chk("rst_readdata", READDATA, 0);
        RESET = 1'b0; READ = 1'b0;
        model_reset();
        #1;
        chk("post_rst_idle", {BUSYWAIT, MEM_READ, MEM_WRITE}, 0);
        chk("post_rst_hits", HIT_COUNT, stat_exp(0));
        chk("post_rst_miss", MISS_COUNT, stat_exp(0));
    endtask

    // One CPU request, checked cycle by cycle against the model
    task automatic do_req(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [1:0]  ob;
        logic [7:0]  a2;
        bit          hit;
        bit          is_wr;
        int          cyc;
        int          base;
        logic [16:0] expq [$];
        idx   = a[4:2];
        tg    = a[7:5];
        is_wr = wr && !rd;
        hit   = mv[idx] && (mt[idx] == tg);
        if (!hit) begin
            if (mv[idx] && md[idx]) begin
                for (int o = 0; o < 4; o++) begin
                    ob = o[1:0];
                    a2 = {mt[idx], idx, ob};
                    expq.push_back({1'b1, a2, arch[a2]});
                end
            end
            for (int o = 0; o < 4; o++) begin
                ob = o[1:0];
                expq.push_back({1'b0, tg, idx, ob, 8'h00});
            end
        end
        base = obs.size();
        last_base = base;
        @(negedge CLK);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        #1;
        chk("busy_at_issue", BUSYWAIT, !hit);
        if (!hit) begin
            cyc = 0;
            while (BUSYWAIT === 1'b1 && cyc < 400) begin
                @(negedge CLK); #1;
                cyc++;
            end
            chk("miss_timeout", BUSYWAIT, 0);
        end
        if (rd) chk("readdata", READDATA, arch[a]);
        last_rd = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
        if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
            exp_miss++;
        end
        exp_hit++;
        if (is_wr) begin
            arch[a] = wd;
            md[idx] = 1'b1;
        end
        chk("txn_count", obs.size() - base, expq.size());
        for (int i = 0; i < expq.size() && base + i < obs.size(); i++)
            chk("txn", obs[base + i], expq[i]);
        chk("hit_count", HIT_COUNT, stat_exp(exp_hit));
        chk("miss_count", MISS_COUNT, stat_exp(exp_miss));
        chk("mem_protocol", resp_err - err_seen, 0);
        err_seen = resp_err;
    endtask

    initial begin
        int cyc;
        int base;
        logic [7:0] a;
        int op;
        do_reset();

        // Cold read miss of 0x04, then spatial hit on 0x05
        do_req(1'b1, 1'b0, 8'h04, 8'h00);
        chk("cold_read_data", last_rd, 8'h07);
        chk("cold_txn_first", obs[last_base], {1'b0, 8'h04, 8'h00});
        chk("cold_txn_last", obs[last_base + 3], {1'b0, 8'h07, 8'h00});
        chk("cold_miss_cnt", MISS_COUNT, stat_exp(1));
        do_req(1'b1, 1'b0, 8'h05, 8'h00);
        chk("spatial_hit_cnt", HIT_COUNT, stat_exp(2));
        chk("spatial_no_txn", obs.size() - last_base, 0);

        // Write hit then conflicting read forces writeback of the dirty line
        do_req(1'b0, 1'b1, 8'h06, 8'h2A);
        do_req(1'b1, 1'b0, 8'h26, 8'h00);
        chk("wb_byte2", obs[last_base + 2], {1'b1, 8'h06, 8'h2A});
        chk("fetch_first", obs[last_base + 4], {1'b0, 8'h24, 8'h00});

        // READ+WRITE together behaves as a read; line stays clean
        do_req(1'b1, 1'b0, 8'h05, 8'h00);
        do_req(1'b1, 1'b1, 8'h05, 8'hEE);
        do_req(1'b1, 1'b0, 8'h06, 8'h00);
        chk("written_byte_back", last_rd, 8'h2A);
        do_req(1'b1, 1'b0, 8'h25, 8'h00);
        chk("clean_evict_txns", obs.size() - last_base, 4);

        // Slow memory: five busy cycles per byte
        lat = 5;
        do_req(1'b0, 1'b1, 8'h0B, 8'h5C);
        do_req(1'b1, 1'b0, 8'h6B, 8'h00);
        do_req(1'b1, 1'b0, 8'h0B, 8'h00);
        chk("slow_mem_data", last_rd, 8'h5C);

        // Randomised traffic over a few tags to provoke conflicts
        for (int n = 0; n < 200; n++) begin
            lat = $urandom_range(1, 3);
            a   = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            op  = $urandom_range(0, 9);
            if (op < 5)      do_req(1'b1, 1'b0, a, 8'($urandom));
            else if (op < 9) do_req(1'b0, 1'b1, a, 8'($urandom));
            else             do_req(1'b1, 1'b1, a, 8'($urandom));
        end

        // Reset during the third fetch byte aborts the refill
        lat = 3;
        do_reset();
        base = obs.size();
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h44;
        cyc = 0;
        while (obs.size() - base < 3 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        chk("third_fetch_reached", obs.size() - base, 3);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0; READ = 1'b0;
        #1;
        chk("abort_idle", {BUSYWAIT, MEM_READ, MEM_WRITE}, 0);
        model_reset();
        err_seen = resp_err;
        do_req(1'b1, 1'b0, 8'h44, 8'h00);
        chk("abort_remiss_txns", obs.size() - last_base, 4);
        chk("abort_remiss_addr", obs[last_base], {1'b0, 8'h44, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
